// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module   : seq_det_pkg
// Purpose  : Shared types, constants and helpers for seq_detector_prog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    localparam int PAT_W_MAX = 32;
    localparam int c_FILL_W  = $clog2(PAT_W_MAX + 1);

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } ovl_mode_e;

    function automatic logic [c_FILL_W-1:0] fill_sat(
        input logic [c_FILL_W-1:0] fill,
        input logic [c_FILL_W-1:0] limit
    );
        return (fill >= limit) ? limit : fill + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter; a same-cycle clear and increment yields 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_detector_prog.sv
// ============================================================================
// Module   : seq_detector_prog
// Purpose  : Run-time programmable serial pattern detector with match counter.
//            Define SEQ_DET_MASK_EN to add a per-bit don't-care mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(4'b1011),
    parameter logic             RST_OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    input  logic             rx_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] cfg_mask,
`endif
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt
);

    logic [PAT_W-1:0]    r_pattern;
    ovl_mode_e           r_overlap;
    logic [PAT_W-1:0]    r_hist;
    logic [c_FILL_W-1:0] r_fill;

    logic [PAT_W-1:0]    w_hist_n;
    logic [c_FILL_W-1:0] w_fill_n;
    logic [c_FILL_W-1:0] w_fill_lim;
    logic                w_hit;
    logic                w_match;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]    r_mask;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mask <= '1;
        end else if (cfg_load) begin
            r_mask <= cfg_mask;
        end
    end

    assign w_hit = (((w_hist_n ^ r_pattern) & r_mask) == '0);
`else
    assign w_hit = (w_hist_n == r_pattern);
`endif

    assign w_hist_n   = {r_hist[PAT_W-2:0], rx};
    assign w_fill_lim = c_FILL_W'(PAT_W);
    assign w_fill_n   = fill_sat(r_fill, w_fill_lim);
    // A config load drops the same-cycle bit, so it can never complete a match.
    assign w_match    = rx_valid && !cfg_load && (w_fill_n == w_fill_lim) && w_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pattern <= RST_PATTERN;
            r_overlap <= ovl_mode_e'(RST_OVERLAP);
            r_hist    <= '0;
            r_fill    <= '0;
            y         <= 1'b0;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_overlap <= ovl_mode_e'(cfg_overlap);
            r_hist    <= '0;
            r_fill    <= '0;
            y         <= 1'b0;
        end else if (rx_valid) begin
            y <= w_match;
            if (w_match && (r_overlap == MODE_NONOVL)) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_hist_n;
                r_fill <= w_fill_n;
            end
        end else begin
            y <= 1'b0;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (w_match),
        .clr  (cnt_clr),
        .cnt  (match_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
// ============================================================================
// Module   : tb_seq_detector_prog
// Purpose  : Scoreboard bench for seq_detector_prog (PAT_W=4, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_prog;

    logic       clk;
    logic       rstn;
    logic       rx;
    logic       rx_valid;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic [3:0] cfg_mask;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       y;
    logic [1:0] match_cnt;

    typedef struct {
        int       idx;
        bit       y;
        bit [1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_idx = 0;

    seq_detector_prog #(
        .PAT_W       (4),
        .CNT_W       (2),
        .RST_PATTERN (4'b1011),
        .RST_OVERLAP (1'b1)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx          (rx),
        .rx_valid    (rx_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask    (cfg_mask),
`endif
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .y           (y),
        .match_cnt   (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are stable at the falling edge; compare against the
    // expectation pushed right after the preceding rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (y !== e.y) begin
                    failures++;
                    $display("FAIL y step=%0d got=%0b expected=%0b", e.idx, y, e.y);
                end
                checks++;
                if (match_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL match_cnt step=%0d got=%0d expected=%0d", e.idx, match_cnt, e.cnt);
                end
            end
        end
    end

    task automatic step(input bit r, input bit v, input bit ld, input bit [3:0] pat,
                        input bit ovl, input bit clr, input bit ey, input bit [1:0] ec);
        exp_t e;
        rx          = r;
        rx_valid    = v;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        cnt_clr     = clr;
        @(posedge clk);
        step_idx++;
        e.idx = step_idx;
        e.y   = ey;
        e.cnt = ec;
        q.push_back(e);
        @(negedge clk);
        rx_valid = 1'b0;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic feed(input bit r, input bit ey, input bit [1:0] ec);
        step(r, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, ey, ec);
    endtask

    task automatic idle(input bit clr, input bit ey, input bit [1:0] ec);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, clr, ey, ec);
    endtask

    task automatic load(input bit [3:0] pat, input bit ovl, input bit r, input bit v,
                        input bit clr, input bit [1:0] ec);
        step(r, v, 1'b1, pat, ovl, clr, 1'b0, ec);
    endtask

    initial begin
        rstn        = 1'b0;
        rx          = 1'b0;
        rx_valid    = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 4'b0000;
        cfg_mask    = 4'b1111;
        cfg_overlap = 1'b0;
        cnt_clr     = 1'b0;

        // Reset state
        idle(1'b0, 1'b0, 2'd0);
        idle(1'b0, 1'b0, 2'd0);
        rstn = 1'b1;
        idle(1'b0, 1'b0, 2'd0);

        // Overlap, reset pattern 1011: stream 1011011
        feed(1, 0, 0); feed(0, 0, 0); feed(1, 0, 0); feed(1, 1, 1);
        feed(0, 0, 1); feed(1, 0, 1); feed(1, 1, 2);
        idle(1'b0, 1'b0, 2'd2);

        // Non-overlap, same stream; counter cleared with the load
        load(4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        feed(1, 0, 0); feed(0, 0, 0); feed(1, 0, 0); feed(1, 1, 1);
        feed(0, 0, 1); feed(1, 0, 1); feed(1, 0, 1);
        idle(1'b0, 1'b0, 2'd1);

        // Gapped stream: three idle cycles between bits
        load(4'b1011, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
        feed(1, 0, 0); repeat (3) idle(1'b0, 1'b0, 2'd0);
        feed(0, 0, 0); repeat (3) idle(1'b0, 1'b0, 2'd0);
        feed(1, 0, 0); repeat (3) idle(1'b0, 1'b0, 2'd0);
        feed(1, 1, 1); repeat (3) idle(1'b0, 1'b0, 2'd1);

        // Load coincident with a valid bit; that bit is dropped
        idle(1'b1, 1'b0, 2'd0);
        feed(1, 0, 0); feed(0, 0, 0); feed(1, 0, 0);
        load(4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        feed(0, 0, 0); feed(1, 0, 0); feed(1, 0, 0); feed(0, 1, 1);

        // Saturation at 3, then clear coincident with a match
        load(4'b1011, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
        feed(1, 0, 0); feed(0, 0, 0); feed(1, 0, 0); feed(1, 1, 1);
        feed(0, 0, 1); feed(1, 0, 1); feed(1, 1, 2);
        feed(0, 0, 2); feed(1, 0, 2); feed(1, 1, 3);
        feed(0, 0, 3); feed(1, 0, 3); feed(1, 1, 3);
        feed(0, 0, 3); feed(1, 0, 3); feed(1, 1, 3);
        feed(0, 0, 3); feed(1, 0, 3);
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1);

        // Reset mid-stream discards partial sequence
        feed(1, 0, 1); feed(0, 0, 1); feed(1, 0, 1);
        rstn = 1'b0;
        idle(1'b0, 1'b0, 2'd0);
        rstn = 1'b1;
        feed(1, 0, 0);
        feed(1, 0, 0); feed(0, 0, 0); feed(1, 0, 0); feed(1, 1, 1);

        // Clear with no match
        idle(1'b1, 1'b0, 2'd0);

`ifdef SEQ_DET_MASK_EN
        cfg_mask = 4'b1001;
        load(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        cfg_mask = 4'b1111;
        feed(1, 0, 0); feed(1, 0, 0); feed(1, 0, 0); feed(1, 1, 1);
`endif

        begin
            int guard;
            guard = 0;
            while (q.size() > 0 && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            if (q.size() > 0) begin
                checks++;
                failures++;
                $display("FAIL drain pending=%0d expected=0", q.size());
            end
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Parametrised, run-time programmable serial bit-pattern detector; successor to the fixed-pattern single-bit detector (`rx` in, `y` out).
- Pattern width is a parameter. The pattern and the overlap/non-overlap mode load at run time. A saturating match counter is added.
- Sits on a serial receive path. It watches a qualified bit stream and flags each occurrence of the programmed sequence to downstream control logic.

Parameters:
- PAT_W, 4, pattern length in bits (2..32).
- CNT_W, 8, match counter width.
- RST_PATTERN, 4'b1011 (width PAT_W), pattern active out of reset.
- RST_OVERLAP, 1, overlap mode active out of reset (1 = overlapping matches allowed).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- rx  in  1  serial data bit.
- rx_valid  in  1  rx qualifier; a bit is consumed only on a clk edge with rx_valid=1.
- cfg_load  in  1  single-cycle strobe; latches cfg_pattern/cfg_overlap.
- cfg_pattern  in  PAT_W  new pattern; MSB is the first bit received.
- cfg_overlap  in  1  new overlap mode.
- cnt_clr  in  1  synchronous clear of match_cnt.
- y  out  1  registered one-cycle match pulse.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (rstn=0, async):
  - hist=0, fill=0, y=0, match_cnt=0.
  - pattern=RST_PATTERN, overlap=RST_OVERLAP.
  - Reset mid-stream discards any partial sequence.
- State:
  - hist[PAT_W-1:0] shift register; the newest bit enters at bit 0.
  - fill counter, 0..PAT_W, saturating; counts bits received since the last restart.
- Consume (rx_valid=1, cfg_load=0):
  - hist_n = {hist[PAT_W-2:0], rx}; fill_n = min(fill+1, PAT_W).
  - match = (fill_n==PAT_W) && (hist_n==pattern).
- Latency:
  - y=1 on the cycle immediately after the edge that consumed the completing bit, for exactly one cycle.
  - y=0 on every other cycle, including cycles with rx_valid=0.
- Overlap=1: fill stays at PAT_W after a match, so a match may reuse trailing bits of the previous one.
- Overlap=0: on a match, fill<=0 and hist<=0. The next match needs PAT_W fresh bits.
- rx_valid=0: hist and fill hold; gaps between bits do not break a sequence.
- cfg_load=1:
  - pattern<=cfg_pattern, overlap<=cfg_overlap; hist<=0, fill<=0, y<=0.
  - Wins over a same-cycle rx_valid; that bit is dropped.
  - match_cnt is unaffected.
- match_cnt:
  - Increments on each match; saturates at 2^CNT_W-1.
  - cnt_clr=1 with no match: 0 next cycle.
  - cnt_clr=1 with a same-cycle match: 1 next cycle (clear, then count).
- Pattern of all zeros or all ones is legal; no special casing.

Optional Feature:
- Macro SEQ_DET_MASK_EN.
- When defined:
  - Adds input cfg_mask [PAT_W], latched with cfg_load; reset value all ones.
  - match uses ((hist_n ^ pattern) & mask) == 0. A mask bit of 0 is don't-care at that position.
  - Fill and overlap rules are unchanged.
- When undefined: no cfg_mask port; exact compare as above.

Decomposition:
- Package seq_det_pkg holds:
  - PAT_W_MAX=32.
  - typedef enum logic {MODE_NONOVL=0, MODE_OVL=1} ovl_mode_e.
  - Helper function fill_sat() for the saturating increment.
- Sub-module sat_counter (parameter W; inputs clk, rstn, inc, clr; output cnt) implements match_cnt with the clear-then-count rule.
- Pattern/mode registers, shift register and fill logic stay in the top module.

Test Plan (PAT_W=4, pattern 1011, rx_valid=1 unless stated):
- Overlap=1, rx stream 1,0,1,1,0,1,1 -> y pulses one cycle after bit 4 and after bit 7; match_cnt=2.
- cfg_load pattern 1011, overlap=0, same stream -> y pulses only after bit 4; match_cnt=1.
- Stream 1,0,1,1 with rx_valid=0 for 3 cycles between each bit -> single y pulse after bit 4; y=0 throughout the gaps.
- Feed 1,0,1; cfg_load (pattern 0110) coincident with rx=1; then feed 0,1,1,0 -> no pulse from the dropped bit; pulse after the final 0; match_cnt=1.
- CNT_W=2, overlap=1, feed 1011 then 011 repeated 4 times -> match_cnt saturates at 3. Then cnt_clr coincident with a match -> match_cnt=1.
- Assert rstn=0 after 1,0,1, release, then feed 1 -> no pulse; four more bits 1,0,1,1 -> pulse. With SEQ_DET_MASK_EN and mask 1001, the stream 1,1,1,1 -> pulse.
